tcb_lib_misalign_split: RTL
===========================

// Module: tcb_lib_misalign_split
// PURPOSE
// - Sits directly upstream of the log-size to byte-enable converter built with aligned accesses only.
// - Splits each misaligned TCB log-size request (little-endian, 32-bit data) into a sequence of
//   naturally aligned log-size requests. Aligned requests pass through as one piece.
// - Reassembles the read data and merges the status before the subordinate response is returned.
// PARAMETERS
// - ADR  32  address width [bits]; addresses wrap modulo 2**ADR
// - DLY  1   fixed response delay of both ports [cycles]; range 0..3
// PORTS
// - clk      in   1    clock
// - rst      in   1    reset, synchronous, active-high
// - sub_vld  in   1    subordinate request valid
// - sub_rdy  out  1    subordinate ready; high only on the handshake of the last piece
// - sub_wen  in   1    write enable
// - sub_adr  in   ADR  byte address, any alignment
// - sub_siz  in   2    log2 of size in bytes; 0..2 legal, 3 gives an error response
// - sub_wdt  in   32   write data, right-aligned (byte 0 = first byte)
// - sub_rdt  out  32   read data, right-aligned; valid DLY cycles after the sub handshake
// - sub_err  out  1    response error, same timing as sub_rdt
// - man_*    vld/rdy/wen/adr/siz/wdt  out (rdy in)  aligned piece request, same widths as sub_*
// - man_rdt  in   32   piece read data, right-aligned
// - man_err  in   1    piece response error
// BEHAVIOUR
// - The manager holds sub_* stable while sub_vld && !sub_rdy. This block relies on that rule.
// - Piece selection: a = sub_adr + cnt, n = 2**sub_siz - cnt, where cnt = bytes already issued.
//   - s = largest value in 0..2 with a % 2**s == 0 and 2**s <= n.
//   - man_adr = a, man_siz = s, man_wdt = sub_wdt >> 8*cnt, man_wen = sub_wen.
// - Pieces per request are 1..3 (e.g. word@+1 issues byte, half, byte).
// - FSM has 2 states, IDLE (cnt = 0) and SPLIT (cnt > 0).
//   - On man_vld && man_rdy: if the piece is the last one (2**s == n), go to IDLE, cnt = 0, sub_rdy = 1.
//   - Otherwise cnt += 2**s and go to SPLIT.
//   - Without a handshake, state and cnt hold.
// - man_vld = sub_vld (combinational, zero added latency). sub_rdy = man_rdy && last.
// - One piece can issue per cycle. Back-to-back sub requests are allowed with no bubble.
// - Response tracking uses a DLY-deep shift register per cycle: {hs, ren, cnt, s, last}.
//   - A non-last piece response writes the low 2**s bytes of man_rdt into rbuf[cnt +: 2**s].
//     It also ORs man_err into an error accumulator.
//   - On the last piece response, sub_rdt is rbuf with the last piece bytes merged combinationally.
//     sub_err is the accumulator OR man_err. The accumulator clears in the same cycle.
//   - Bytes above 2**sub_siz in sub_rdt are zero.
// - DLY = 0: response bytes merge in the handshake cycle. rbuf holds only earlier pieces.
// - sub_siz = 3: no man access. sub_rdy = 1 immediately and sub_err = 1 after DLY cycles.
// - Reset values: state IDLE, cnt 0, tracking pipe empty, accumulator 0, rbuf 0.
//   man_vld follows sub_vld, so the manager must keep sub_vld low during reset.
// - Reset mid-split aborts the request. In-flight piece responses are discarded and no sub response is produced.
// - man_adr wrap past 2**ADR-1 goes to 0 without error.
// CONFIGURATION
// - Macro TCB_LIB_MISALIGN_TRAP_EN.
//   - Defined: misaligned requests (sub_adr % 2**sub_siz != 0) are not split. They complete in
//     1 cycle with sub_rdy = 1, no man_vld, sub_err = 1 after DLY cycles and sub_rdt = 0.
//     Aligned requests behave as above.
//   - Undefined: all requests are split as specified.
// TESTING
// - Aligned read word@0x100, man_rdt=0xCAFEBABE -> 1 piece siz=2, sub_rdt=0xCAFEBABE after DLY.
// - Write word 0x11223344@0x101 -> pieces byte@0x101 wdt[7:0]=0x44, half@0x102 wdt[15:0]=0x2233,
//   byte@0x104 wdt[7:0]=0x11; sub_rdy only on the 3rd handshake.
// - Read half@0x103, man_rdt 0xAA then 0xBB -> bytes @0x103 and @0x104, sub_rdt=0x0000BBAA.
// - Read word@0x102 with man_rdy low 2 cycles between pieces, halves 0xBBAA then 0xDDCC
//   -> cnt holds while stalled, sub_rdt=0xDDCCBBAA, 2 man handshakes.
// - Word@0x1 with man_err=1 on piece 2 only -> sub_err=1 on the final response, next request sub_err=0.
// - rst pulse after piece 1 of word@0x3 -> IDLE, cnt=0, no sub response. Next aligned read completes
//   normally. With TCB_LIB_MISALIGN_TRAP_EN, word@0x3 -> sub_err=1 and no man_vld.

Source files
------------

// File: rtl/tcb_lib_misalign_split.sv
// Splits misaligned TCB log-size requests into naturally aligned pieces and reassembles the response.
// Optional macro TCB_LIB_MISALIGN_TRAP_EN: misaligned requests are rejected with an error instead of split.
module tcb_lib_misalign_split #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DLY = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_sub_vld,
    output logic           o_sub_rdy,
    input  logic           i_sub_wen,
    input  logic [ADR-1:0] i_sub_adr,
    input  logic [1:0]     i_sub_siz,
    input  logic [31:0]    i_sub_wdt,
    output logic [31:0]    o_sub_rdt,
    output logic           o_sub_err,
    output logic           o_man_vld,
    input  logic           i_man_rdy,
    output logic           o_man_wen,
    output logic [ADR-1:0] o_man_adr,
    output logic [1:0]     o_man_siz,
    output logic [31:0]    o_man_wdt,
    input  logic [31:0]    i_man_rdt,
    input  logic           i_man_err
);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    typedef struct packed {
        logic       hs;
        logic       ferr;
        logic       ren;
        logic [1:0] cnt;
        logic [1:0] siz;
        logic       last;
    } trk_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_cnt, w_cnt_nxt;
    logic [ADR-1:0] w_a;
    logic [2:0]     w_n, w_pb, w_pb_rsp, w_off;
    logic [1:0]     w_s;
    logic           w_last, w_bypass, w_hs, w_ehs;
    trk_t           w_trk_in, w_trk;
    logic [31:0]    r_rbuf, w_pdat;
    logic           r_acc;

    // Piece selection: largest aligned size fitting in the remaining bytes
    always_comb begin
        w_n = (3'd1 << i_sub_siz) - {1'b0, r_cnt};
        w_a = i_sub_adr + ADR'(r_cnt);
        if (w_a[1:0] == 2'd0 && w_n >= 3'd4) begin
            w_s = 2'd2;
        end else if (!w_a[0] && w_n >= 3'd2) begin
            w_s = 2'd1;
        end else begin
            w_s = 2'd0;
        end
        w_pb   = 3'd1 << w_s;
        w_last = (w_pb == w_n);
`ifdef TCB_LIB_MISALIGN_TRAP_EN
        w_bypass = (i_sub_siz == 2'd3)
                 || (i_sub_siz == 2'd1 && i_sub_adr[0])
                 || (i_sub_siz == 2'd2 && i_sub_adr[1:0] != 2'd0);
`else
        w_bypass = (i_sub_siz == 2'd3);
`endif
    end

    // FSM outputs: piece request and subordinate ready
    always_comb begin
        o_man_vld = i_sub_vld && !w_bypass;
        o_man_wen = i_sub_wen;
        o_man_adr = w_a;
        o_man_siz = w_s;
        o_man_wdt = i_sub_wdt >> {r_cnt, 3'b000};
        if (w_bypass) begin
            o_sub_rdy = 1'b1;
        end else begin
            o_sub_rdy = i_man_rdy && w_last;
        end
    end

    assign w_hs  = o_man_vld && i_man_rdy;
    assign w_ehs = i_sub_vld && w_bypass;

    // FSM next state: advance the byte count on every non-last piece handshake
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_hs) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 2'd0;
            end else begin
                w_state_nxt = SPLIT;
                w_cnt_nxt   = r_cnt + w_pb[1:0];
            end
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Per-cycle tracking entry; rejected requests ride along as forced-error last pieces
    always_comb begin
        w_trk_in.hs   = (w_hs || w_ehs) && !i_rst;
        w_trk_in.ferr = w_ehs;
        w_trk_in.ren  = !i_sub_wen;
        w_trk_in.cnt  = r_cnt;
        w_trk_in.siz  = w_s;
        w_trk_in.last = w_last || w_ehs;
    end

    generate
        if (DLY == 0) begin : g_nodly
            assign w_trk = w_trk_in;
        end else begin : g_dly
            trk_t r_pipe [DLY];
            // Response tracking delay line
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_trk_in;
                    for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_trk = r_pipe[DLY-1];
        end
    endgenerate

    // Merge the low bytes of the piece response into the buffer at the piece offset
    always_comb begin
        w_pb_rsp = 3'd1 << w_trk.siz;
        w_pdat   = r_rbuf;
        w_off    = 3'd0;
        for (int b = 0; b < 4; b++) begin
            w_off = 3'(b) - {1'b0, w_trk.cnt};
            if (3'(b) >= {1'b0, w_trk.cnt} && w_off < w_pb_rsp) begin
                w_pdat[8*b +: 8] = i_man_rdt[{w_off[1:0], 3'b000} +: 8];
            end else begin
                w_pdat[8*b +: 8] = r_rbuf[8*b +: 8];
            end
        end
    end

    // Subordinate response on the last piece
    always_comb begin
        o_sub_rdt = 32'd0;
        o_sub_err = 1'b0;
        if (w_trk.hs && w_trk.last) begin
            if (w_trk.ferr) begin
                o_sub_err = 1'b1;
            end else begin
                o_sub_err = r_acc | i_man_err;
                o_sub_rdt = w_trk.ren ? w_pdat : 32'd0;
            end
        end else begin
            o_sub_rdt = 32'd0;
            o_sub_err = 1'b0;
        end
    end

    // Read buffer and error accumulator across pieces of one request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rbuf <= 32'd0;
            r_acc  <= 1'b0;
        end else if (w_trk.hs && w_trk.last) begin
            r_rbuf <= 32'd0;
            r_acc  <= 1'b0;
        end else if (w_trk.hs) begin
            r_acc <= r_acc | i_man_err;
            if (w_trk.ren) r_rbuf <= w_pdat;
        end else begin
            r_rbuf <= r_rbuf;
            r_acc  <= r_acc;
        end
    end

endmodule
